// File: rtl/if_id_queue_if.sv
// Handshake and data bundle between fetch, the IF/ID queue and decode.
// The queue takes the slave side; the surrounding pipeline (or a bench) takes master.
interface if_id_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic        in_bd;
    logic [4:0]  in_excode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC4_D;
    logic [31:0] PC8_D;
    logic        BD_D;
    logic [4:0]  excode_D;

    modport master (
        output in_valid, Instr, PC, in_bd, in_excode, out_ready,
        input  in_ready, out_valid, IR_D, PC_D, PC4_D, PC8_D, BD_D, excode_D
    );

    modport slave (
        input  in_valid, Instr, PC, in_bd, in_excode, out_ready,
        output in_ready, out_valid, IR_D, PC_D, PC4_D, PC8_D, BD_D, excode_D
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry fetch-to-decode instruction queue with valid/ready on both sides,
// flush on redirect, and reserved-instruction detection merged into the head exception code.
module if_id_queue #(
    parameter int DEPTH    = 2,
    parameter bit RI_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    if_id_queue_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [4:0]       EXC_RI   = 5'd10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  excode;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    entry_t           head;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Decoder coverage: anything outside this set raises RI when it reaches the head.
    function automatic logic is_supported(input logic [31:0] w);
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [5:0] funct;
        logic       ok;
        op    = w[31:26];
        rs    = w[25:21];
        rt    = w[20:16];
        funct = w[5:0];
        ok    = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h08, 6'h09, 6'h21, 6'h23, 6'h20, 6'h22, 6'h00, 6'h02,
                    6'h03, 6'h04, 6'h06, 6'h07, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12,
                    6'h11, 6'h13: ok = 1'b1;
                    default:      ok = 1'b0;
                endcase
            end
            6'h01:                                          ok = (rt == 5'h00) || (rt == 5'h01);
            6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07:       ok = 1'b1;
            6'h0F, 6'h0D, 6'h08, 6'h09, 6'h0C, 6'h0E,
            6'h0A, 6'h0B, 6'h23, 6'h20, 6'h24, 6'h21,
            6'h25, 6'h2B, 6'h29, 6'h28:                     ok = 1'b1;
            6'h10:                                          ok = (rs == 5'h00) || (rs == 5'h04) || (w == 32'h4200_0018);
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign bus.in_ready  = (count != FULL_CNT);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Reset and flush both clear the pointers, dropping any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wr_ptr] <= '{instr: bus.Instr, pc: bus.PC, bd: bus.in_bd, excode: bus.in_excode};
        end
    end

    // The storage array is never reset, so an empty queue must mask it to a bubble.
    always_comb begin
        head = '0;
        if (bus.out_valid) head = mem[rd_ptr];
    end

    assign bus.IR_D  = head.instr;
    assign bus.PC_D  = head.pc;
    assign bus.PC4_D = head.pc + 32'd4;
    assign bus.PC8_D = head.pc + 32'd8;
    assign bus.BD_D  = head.bd;

    always_comb begin
        bus.excode_D = 5'd0;
        if (head.excode != 5'd0) begin
            bus.excode_D = head.excode;
        end else if (RI_CHECK && bus.out_valid && !is_supported(head.instr)) begin
            bus.excode_D = EXC_RI;
        end
    end

endmodule
